// File: rtl/mem_responder.sv
// mem_responder: single-clock memory-mapped responder for a small processor.
// Regions on ADDR[15:12]: 0x0 RAM, 0x1 LED register, 0x2 interval timer, 0x3 switches.
// All other regions read as zero and ignore writes. Read data is registered (1-cycle latency).
// Optional feature macro: MEM_RESPONDER_TIMER_EN enables the timer region and TIRQ;
// without it the timer region is unmapped and TIRQ is tied low.
module mem_responder #(
    parameter int unsigned RAM_AW = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] DIN,
    input  logic [8:0]  SW,
    output logic [8:0]  LEDR,
    output logic        TIRQ
);

    localparam int unsigned RamDepth = 2 ** RAM_AW;

    logic [3:0]        w_region;
    logic              w_sel_ram;
    logic              w_sel_led;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [15:0]       w_ram_rdata;
    logic [15:0]       w_tmr_rdata;
    logic [15:0]       w_rdata;
    logic              w_unused;

    logic [15:0]       r_ram [RamDepth];
    logic [15:0]       r_din;
    logic [8:0]        r_ledr;

    assign w_region  = ADDR[15:12];
    assign w_sel_ram = (w_region == 4'h0);
    assign w_sel_led = (w_region == 4'h1);
    assign w_ram_idx = ADDR[RAM_AW-1:0];

    // Address bits above the RAM index and upper data bits are deliberately ignored.
    assign w_unused = ^{ADDR, DOUT};

    // RAM storage: never reset; a write presented on a reset edge is discarded.
    always_ff @(posedge Clock) begin
        if (!Reset && W && w_sel_ram) begin
            r_ram[w_ram_idx] <= DOUT;
        end
    end

    // Combinational array read; registering it in r_din yields read-old-data on collisions.
    assign w_ram_rdata = r_ram[w_ram_idx];

    // LED register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ledr <= 9'h000;
        end else if (W && w_sel_led) begin
            r_ledr <= DOUT[8:0];
        end
    end

`ifdef MEM_RESPONDER_TIMER_EN
    logic        w_sel_tmr;
    logic        w_tmr_wr;
    logic        w_expire;
    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic        r_en;
    logic        r_exp;

    assign w_sel_tmr = (w_region == 4'h2);
    assign w_tmr_wr  = W && w_sel_tmr;
    // COUNT==1 can only coexist with a non-zero RELOAD, so this never fires for RELOAD=0.
    assign w_expire  = r_en && (r_count == 16'd1);

    // Timer configuration registers: RELOAD and CTRL.EN.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_reload <= 16'h0000;
            r_en     <= 1'b0;
        end else begin
            if (w_tmr_wr && (ADDR[1:0] == 2'd0)) begin
                r_reload <= DOUT;
            end
            if (w_tmr_wr && (ADDR[1:0] == 2'd1)) begin
                r_en <= DOUT[0];
            end
        end
    end

    // Down-counter: a RELOAD write beats the decrement; holds at 0 when RELOAD is 0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count <= 16'h0000;
        end else if (w_tmr_wr && (ADDR[1:0] == 2'd0)) begin
            r_count <= DOUT;
        end else if (r_en) begin
            if (w_expire) begin
                r_count <= r_reload;
            end else if (r_count != 16'h0000) begin
                r_count <= r_count - 16'd1;
            end
        end
    end

    // Expiry flag: set on expiry, cleared when STATUS is read unless expiry occurs together.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_exp <= 1'b0;
        end else if (w_expire) begin
            r_exp <= 1'b1;
        end else if (w_sel_tmr && (ADDR[1:0] == 2'd2)) begin
            r_exp <= 1'b0;
        end
    end

    // Timer register read mux.
    always_comb begin
        w_tmr_rdata = 16'h0000;
        case (ADDR[1:0])
            2'd0:    w_tmr_rdata = r_reload;
            2'd1:    w_tmr_rdata = {15'h0000, r_en};
            2'd2:    w_tmr_rdata = {15'h0000, r_exp};
            default: w_tmr_rdata = r_count;
        endcase
    end

    assign TIRQ = r_exp;
`else
    assign w_tmr_rdata = 16'h0000;
    assign TIRQ        = 1'b0;
`endif

    // Region read mux.
    always_comb begin
        w_rdata = 16'h0000;
        case (w_region)
            4'h0:    w_rdata = w_ram_rdata;
            4'h1:    w_rdata = {7'h00, r_ledr};
`ifdef MEM_RESPONDER_TIMER_EN
            4'h2:    w_rdata = w_tmr_rdata;
`endif
            4'h3:    w_rdata = {7'h00, SW};
            default: w_rdata = 16'h0000;
        endcase
    end

    // Registered read data, updated every cycle regardless of W.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_din <= 16'h0000;
        end else begin
            r_din <= w_rdata;
        end
    end

    assign DIN  = r_din;
    assign LEDR = r_ledr;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a randomized
// RAM/LED/switch/unmapped sweep against a behavioural model.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] din;
    logic [8:0]  sw;
    logic [8:0]  ledr;
    logic        tirq;

    int n_checks;
    int n_pass;

    // Behavioural model state for the randomized sweep.
    logic [15:0] ram_m [16];
    logic [8:0]  led_m;

    mem_responder #(.RAM_AW(8)) dut (
        .Clock (clk),
        .Reset (rst),
        .ADDR  (addr),
        .DOUT  (dout),
        .W     (w),
        .DIN   (din),
        .SW    (sw),
        .LEDR  (ledr),
        .TIRQ  (tirq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        w    = 1'b1;
        addr = 16'h1000;
        dout = 16'h01FF;
        sw   = 9'h155;
        cycle();
        cycle();
        n_checks++;
        if (din !== 16'h0000) $display("FAIL reset_din: got %h want %h", din, 16'h0000);
        else n_pass++;
        n_checks++;
        if (ledr !== 9'h000) $display("FAIL reset_ledr: got %h want %h", ledr, 9'h000);
        else n_pass++;
        n_checks++;
        if (tirq !== 1'b0) $display("FAIL reset_tirq: got %b want 0", tirq);
        else n_pass++;
        rst  = 1'b0;
        w    = 1'b0;
        addr = 16'h4000;
        cycle();
        n_checks++;
        if (ledr !== 9'h000) $display("FAIL reset_write_discarded: got %h want %h", ledr, 9'h000);
        else n_pass++;
    endtask

    task automatic test_ram_basic();
        w = 1'b1; addr = 16'h0005; dout = 16'hBEEF;
        cycle();
        w = 1'b0; addr = 16'h0005;
        cycle();
        n_checks++;
        if (din !== 16'hBEEF) $display("FAIL ram_wr_rd: got %h want %h", din, 16'hBEEF);
        else n_pass++;
    endtask

    task automatic test_read_during_write();
        w = 1'b1; addr = 16'h0007; dout = 16'h1111;
        cycle();
        w = 1'b1; addr = 16'h0007; dout = 16'h2222;
        cycle();
        n_checks++;
        if (din !== 16'h1111) $display("FAIL rdw_old: got %h want %h", din, 16'h1111);
        else n_pass++;
        w = 1'b0;
        cycle();
        n_checks++;
        if (din !== 16'h2222) $display("FAIL rdw_new: got %h want %h", din, 16'h2222);
        else n_pass++;
    endtask

    task automatic test_led_switch();
        w = 1'b1; addr = 16'h1000; dout = 16'h01A5;
        cycle();
        n_checks++;
        if (ledr !== 9'h1A5) $display("FAIL led_write: got %h want %h", ledr, 9'h1A5);
        else n_pass++;
        // Writes to switch and unmapped regions must not disturb anything.
        w = 1'b1; addr = 16'h3000; dout = 16'h0000;
        cycle();
        addr = 16'h7000;
        cycle();
        w = 1'b0; sw = 9'h0F0; addr = 16'h3000;
        cycle();
        n_checks++;
        if (din !== 16'h00F0) $display("FAIL sw_read: got %h want %h", din, 16'h00F0);
        else n_pass++;
        addr = 16'h4000;
        cycle();
        n_checks++;
        if (din !== 16'h0000) $display("FAIL unmapped_read: got %h want %h", din, 16'h0000);
        else n_pass++;
        addr = 16'h1000;
        cycle();
        n_checks++;
        if (din !== 16'h01A5) $display("FAIL led_read: got %h want %h", din, 16'h01A5);
        else n_pass++;
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] lo;
        logic [3:0]  idx;
        logic [15:0] data;
        logic [15:0] expd;
        logic        wr;
        // Seed the 16 RAM words the sweep uses so every read has a known value.
        for (int i = 0; i < 16; i++) begin
            data = 16'($urandom);
            ram_m[i] = data;
            w = 1'b1; addr = 16'(i); dout = data;
            cycle();
        end
        w = 1'b0;
        led_m = ledr === 9'h1A5 ? 9'h1A5 : 9'h1A5;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 15));
`ifdef MEM_RESPONDER_TIMER_EN
            if (r == 2) r = 0;
`endif
            lo   = $urandom;
            idx  = lo[3:0];
            wr   = 1'($urandom_range(0, 1));
            data = 16'($urandom);
            sw   = 9'($urandom);
            if (r == 0) addr = {4'h0, lo[11:8], 4'h0, idx};
            else        addr = {r[3:0], lo[11:0]};
            case (r)
                0:       expd = ram_m[idx];
                1:       expd = {7'h00, led_m};
                3:       expd = {7'h00, sw};
                default: expd = 16'h0000;
            endcase
            w = wr; dout = data;
            cycle();
            n_checks++;
            if (din !== expd) $display("FAIL rand_din[%0d]: addr %h got %h want %h", i, addr, din, expd);
            else n_pass++;
            if (wr && r == 0) ram_m[idx] = data;
            if (wr && r == 1) led_m = data[8:0];
            n_checks++;
            if (ledr !== led_m) $display("FAIL rand_ledr[%0d]: got %h want %h", i, ledr, led_m);
            else n_pass++;
            n_checks++;
            if (tirq !== 1'b0) $display("FAIL rand_tirq[%0d]: got %b want 0", i, tirq);
            else n_pass++;
        end
        w = 1'b0;
    endtask

`ifdef MEM_RESPONDER_TIMER_EN
    task automatic test_timer();
        logic [15:0] cnt_exp [4];
        logic        irq_exp [4];
        cnt_exp[0] = 16'd3; cnt_exp[1] = 16'd2; cnt_exp[2] = 16'd1; cnt_exp[3] = 16'd3;
        irq_exp[0] = 1'b0;  irq_exp[1] = 1'b0;  irq_exp[2] = 1'b1;  irq_exp[3] = 1'b1;
        w = 1'b1; addr = 16'h2000; dout = 16'd3;
        cycle();
        addr = 16'h2001; dout = 16'd1;
        cycle();
        w = 1'b0; addr = 16'h2003;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (din !== cnt_exp[i]) $display("FAIL tmr_count[%0d]: got %h want %h", i, din, cnt_exp[i]);
            else n_pass++;
            n_checks++;
            if (tirq !== irq_exp[i]) $display("FAIL tmr_irq[%0d]: got %b want %b", i, tirq, irq_exp[i]);
            else n_pass++;
        end
        // COUNT is now 2; this read edge moves it to 1 and clears EXP.
        addr = 16'h2002;
        cycle();
        n_checks++;
        if (din !== 16'h0001) $display("FAIL tmr_status: got %h want %h", din, 16'h0001);
        else n_pass++;
        n_checks++;
        if (tirq !== 1'b0) $display("FAIL tmr_status_clear: got %b want 0", tirq);
        else n_pass++;
        // STATUS read on the expiry edge: EXP must stay set.
        cycle();
        n_checks++;
        if (din !== 16'h0000) $display("FAIL tmr_status_coll_din: got %h want %h", din, 16'h0000);
        else n_pass++;
        n_checks++;
        if (tirq !== 1'b1) $display("FAIL tmr_status_coll_irq: got %b want 1", tirq);
        else n_pass++;
        // RELOAD write while running wins over the decrement; RELOAD=0 then holds COUNT at 0.
        w = 1'b1; addr = 16'h2000; dout = 16'd0;
        cycle();
        w = 1'b0; addr = 16'h2002;
        cycle();
        n_checks++;
        if (din !== 16'h0001) $display("FAIL tmr_status2: got %h want %h", din, 16'h0001);
        else n_pass++;
        addr = 16'h2003;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (din !== 16'h0000 || tirq !== 1'b0)
                $display("FAIL tmr_reload0[%0d]: got count %h irq %b want 0000/0", i, din, tirq);
            else n_pass++;
        end
    endtask
`else
    task automatic test_no_timer();
        w = 1'b1; addr = 16'h2000; dout = 16'd5;
        cycle();
        addr = 16'h2001; dout = 16'd1;
        cycle();
        w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 16'h2000 + 16'(i);
            cycle();
            n_checks++;
            if (din !== 16'h0000) $display("FAIL notmr_read[%0d]: got %h want %h", i, din, 16'h0000);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if (tirq !== 1'b0) $display("FAIL notmr_tirq[%0d]: got %b want 0", i, tirq);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_reset_priority();
        w = 1'b1; addr = 16'h0005; dout = 16'hBEEF;
        cycle();
        addr = 16'h1000; dout = 16'h01FF;
        cycle();
`ifdef MEM_RESPONDER_TIMER_EN
        addr = 16'h2000; dout = 16'd2;
        cycle();
        addr = 16'h2001; dout = 16'd1;
        cycle();
        w = 1'b0; addr = 16'h4000;
        cycle();
        cycle();
        cycle();
`endif
        n_checks++;
        if (ledr !== 9'h1FF) $display("FAIL rstp_led_pre: got %h want %h", ledr, 9'h1FF);
        else n_pass++;
        // Reset with a RAM write presented: the write must be discarded.
        rst = 1'b1; w = 1'b1; addr = 16'h0005; dout = 16'h1234;
        cycle();
        n_checks++;
        if (ledr !== 9'h000 || tirq !== 1'b0 || din !== 16'h0000)
            $display("FAIL rstp_state: got led %h irq %b din %h want 000/0/0000", ledr, tirq, din);
        else n_pass++;
        rst = 1'b0; w = 1'b0; addr = 16'h0005;
        cycle();
        n_checks++;
        if (din !== 16'hBEEF) $display("FAIL rstp_ram_kept: got %h want %h", din, 16'hBEEF);
        else n_pass++;
`ifdef MEM_RESPONDER_TIMER_EN
        addr = 16'h2003;
        cycle();
        n_checks++;
        if (din !== 16'h0000) $display("FAIL rstp_count: got %h want %h", din, 16'h0000);
        else n_pass++;
        addr = 16'h2001;
        cycle();
        n_checks++;
        if (din !== 16'h0000) $display("FAIL rstp_en: got %h want %h", din, 16'h0000);
        else n_pass++;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst  = 1'b1;
        w    = 1'b0;
        addr = 16'h0000;
        dout = 16'h0000;
        sw   = 9'h000;
        test_reset();
        test_ram_basic();
        test_read_during_write();
        test_led_switch();
        test_random();
`ifdef MEM_RESPONDER_TIMER_EN
        test_timer();
`else
        test_no_timer();
`endif
        test_reset_priority();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
